// File: rtl/counter_load_tc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : counter_load_tc_pkg                                     |
// | Purpose  : Shared constants for the CA2 datapath counter: default  |
// |            width and the all-ones / zero patterns of that width.   |
// | Ports    : none (package)                                          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package counter_load_tc_pkg;

   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_ONES = '1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

endpackage : counter_load_tc_pkg
`default_nettype wire

// File: rtl/counter_load_tc_and.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : And                                                     |
// | Purpose  : W-input AND reduction stage.                            |
// | Ports    : a [W-1:0] in  - operands                                |
// |            y         out - AND of all bits of a                    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module And
   import counter_load_tc_pkg::*;
#(
   parameter int unsigned W = CNT_W + 1
) (
   input  logic [W-1:0] a,
   output logic         y
);

   assign y = &a;

endmodule : And
`default_nettype wire

// File: rtl/counter_load_tc_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : CounterBit                                              |
// | Purpose  : One slice of the loadable ripple-toggle counter.        |
// | Ports    : clk   in  - clock, rising edge                          |
// |            rst   in  - synchronous active-high reset               |
// |            ld    in  - parallel load strobe                        |
// |            d     in  - load data for this bit                      |
// |            t_in  in  - toggle request from the lower bits          |
// |            q     out - registered bit value                        |
// |            t_out out - toggle request to the next bit              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module CounterBit
   import counter_load_tc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ld,
   input  logic d,
   input  logic t_in,
   output logic q,
   output logic t_out
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 1'b0;
      end else if (ld) begin
         r_q <= d;
      end else if (t_in) begin
         r_q <= ~r_q;
      end
   end

   assign q     = r_q;
   // This bit and every lower bit are one and enabled: the next bit toggles.
   assign t_out = r_q & t_in;

endmodule : CounterBit
`default_nettype wire

// File: rtl/counter_load_tc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : counter_load_tc                                         |
// | Purpose  : Loadable N-bit synchronous up-counter with terminal-    |
// |            count carry-out for cascading.                          |
// | Ports    : clk    in  - clock, rising edge                         |
// |            rst    in  - synchronous active-high reset (cnt <= 0)   |
// |            ld     in  - load par_in (beats en)                     |
// |            en     in  - count enable                               |
// |            par_in in  - [N-1:0] load value                         |
// |            cnt    out - [N-1:0] registered count                   |
// |            co     out - &{en, cnt}, combinational                  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module counter_load_tc
   import counter_load_tc_pkg::*;
#(
   parameter int unsigned N = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         en,
   input  logic [N-1:0] par_in,
   output logic [N-1:0] cnt,
   output logic         co
);

   logic [N-1:0] w_q;
   logic [N-1:0] w_t;
   logic         w_chain_unused;

   assign w_t[0] = en;

   generate
      for (genvar i = 0; i < N; i++) begin : g_bit
         if (i < N - 1) begin : g_mid
            CounterBit u_bit (
               .clk   (clk),
               .rst   (rst),
               .ld    (ld),
               .d     (par_in[i]),
               .t_in  (w_t[i]),
               .q     (w_q[i]),
               .t_out (w_t[i+1])
            );
         end else begin : g_top
            // The chain's final toggle output is not the carry; co comes
            // only from the reduction stage below.
            CounterBit u_bit (
               .clk   (clk),
               .rst   (rst),
               .ld    (ld),
               .d     (par_in[i]),
               .t_in  (w_t[i]),
               .q     (w_q[i]),
               .t_out (w_chain_unused)
            );
         end
      end
   endgenerate

   assign cnt = w_q;

   // co ignores ld/rst on purpose: a cascade gates its next stage with ~ld.
   And #(.W(N + 1)) u_co_and (
      .a ({en, w_q}),
      .y (co)
   );

endmodule : counter_load_tc
`default_nettype wire

// File: tb/tb_counter_load_tc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_counter_load_tc                                      |
// | Purpose  : Self-checking bench for counter_load_tc at N=4, plus    |
// |            carry-period sweeps at N=2 and N=8.                     |
// | Ports    : none                                                    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_counter_load_tc;
   import counter_load_tc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // N = 4 instance
   logic             rst, ld, en;
   logic [CNT_W-1:0] par_in, cnt;
   logic             co;

   // width-sweep instances
   logic       rst2, en2, co2;
   logic [1:0] cnt2;
   logic       rst8, en8, co8;
   logic [7:0] cnt8;

   counter_load_tc #(.N(CNT_W)) u_dut (
      .clk(clk), .rst(rst), .ld(ld), .en(en),
      .par_in(par_in), .cnt(cnt), .co(co)
   );

   counter_load_tc #(.N(2)) u_dut2 (
      .clk(clk), .rst(rst2), .ld(1'b0), .en(en2),
      .par_in(2'b00), .cnt(cnt2), .co(co2)
   );

   counter_load_tc #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst8), .ld(1'b0), .en(en8),
      .par_in(8'h00), .cnt(cnt8), .co(co8)
   );

   int total = 0;
   int bad   = 0;

   logic [CNT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] m_cnt;
   bit               m_valid = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle on the N=4 instance: check co combinationally before the
   // edge, push the expected next count, and pop/compare it after the edge.
   task automatic step(input logic r, input logic l, input logic e,
                       input logic [CNT_W-1:0] p);
      logic [CNT_W-1:0] want;
      @(negedge clk);
      rst = r; ld = l; en = e; par_in = p;
      #1;
      if (m_valid) check_eq("co", {31'd0, co}, {31'd0, (e && m_cnt == CNT_ONES)});
      if (r)      m_cnt = CNT_ZERO;
      else if (l) m_cnt = p;
      else if (e) m_cnt = m_cnt + 1'b1;
      m_valid = 1'b1;
      exp_q.push_back(m_cnt);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         want = exp_q.pop_front();
         check_eq("cnt", {28'd0, cnt}, {28'd0, want});
      end
   endtask

   initial begin
      int pulses2, pulses8, last2, last8;
      rst = 1'b0; ld = 1'b0; en = 1'b0; par_in = '0;
      rst2 = 1'b0; en2 = 1'b0; rst8 = 1'b0; en8 = 1'b0;
      m_cnt = '0;

      // reset beats simultaneous ld and en, and holds
      step(1, 1, 1, 4'hA);
      check_eq("rst_co", {31'd0, co}, 32'd0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 4'h0);

      // count 17 edges: 1..15, 0, 1
      for (int i = 0; i < 17; i++) step(0, 0, 1, 4'h0);

      // load priority over enable
      step(0, 1, 0, 4'h3);
      step(0, 1, 1, 4'hC);
      step(0, 0, 1, 4'h0);

      // hold at all ones, then carry on raising en
      step(0, 1, 0, 4'hF);
      step(0, 0, 0, 4'h0);
      step(0, 0, 1, 4'h0);
      step(0, 0, 0, 4'h0);

      // co high during a load while cnt is all ones
      step(0, 1, 0, 4'hF);
      step(0, 1, 1, 4'h5);

      // reset mid-count
      step(0, 1, 0, 4'h8);
      step(0, 0, 1, 4'h0);
      step(1, 0, 1, 4'h0);
      step(0, 0, 1, 4'h0);

      // ld held high reloads each cycle
      step(0, 1, 1, 4'h7);
      step(0, 1, 1, 4'h7);

      // random mix
      for (int i = 0; i < 60; i++)
         step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 0,
              $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));

      // width sweep: steady counting from 0 at N=2 and N=8
      @(negedge clk);
      rst2 = 1'b1; rst8 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0; rst8 = 1'b0; en2 = 1'b1; en8 = 1'b1;
      pulses2 = 0; pulses8 = 0; last2 = -1; last8 = -1;
      for (int k = 0; k < 600; k++) begin
         #1;
         check_eq("cnt2", {30'd0, cnt2}, k % 4);
         check_eq("co2",  {31'd0, co2},  {31'd0, (k % 4 == 3)});
         check_eq("cnt8", {24'd0, cnt8}, k % 256);
         check_eq("co8",  {31'd0, co8},  {31'd0, (k % 256 == 255)});
         if (co2) begin
            if (last2 >= 0) check_eq("per2", k - last2, 32'd4);
            last2 = k; pulses2++;
         end
         if (co8) begin
            if (last8 >= 0) check_eq("per8", k - last8, 32'd256);
            last8 = k; pulses8++;
         end
         @(negedge clk);
      end
      check_eq("pulses2", pulses2, 32'd150);
      check_eq("pulses8", pulses8, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_counter_load_tc
`default_nettype wire
